// File: rtl/wave_sample_packer.sv
// wave_sample_packer: packs pairs of 16-bit samples into 32-bit words, with flush-to-pad support
module wave_sample_packer #(
  parameter logic [15:0] PAD = 16'h0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        half_full,
  output logic [31:0] word_count
);
  typedef enum logic {EVEN, ODD} state_t;
  state_t      state, state_nxt;
  logic [15:0] low_q;
  logic        flush_pending;
  logic        out_free, in_xfer, out_xfer, load_word, load_flush;

  assign out_free   = !m_valid || m_ready;
  assign in_xfer    = s_valid && s_ready;
  assign out_xfer   = m_valid && m_ready;
  assign load_word  = in_xfer && state == ODD;
  assign load_flush = flush_pending && state == ODD && out_free;

  // State register: EVEN waits for the low sample, ODD holds it awaiting its partner
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= EVEN;
    else        state <= state_nxt;
  end

  // Next state: completing a word (sample or flush) returns to EVEN, a low sample moves to ODD
  always_comb begin
    state_nxt = (load_word || load_flush) ? EVEN : (in_xfer ? ODD : state);
  end

  // Outputs: input is blocked by disable, a pending flush, or a full output stage when a word is due
  always_comb begin
    s_ready   = !areset && enable && !flush_pending && (state == EVEN || out_free);
    half_full = state == ODD;
  end

  // Datapath: low holding register, output word stage, flush flag and handshake counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      low_q         <= '0;
      m_data        <= '0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      flush_pending <= 1'b0;
      word_count    <= '0;
    end else begin
      if (in_xfer && state == EVEN) low_q <= s_data;
      if (load_word || load_flush) begin
        m_data  <= {load_word ? s_data : PAD, low_q};
        m_valid <= 1'b1;
        m_last  <= load_flush;
      end else if (out_xfer) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      flush_pending <= flush_pending ? (state == ODD && !out_free) : flush;
      if (out_xfer) word_count <= word_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_wave_sample_packer.sv
// tb_wave_sample_packer: directed stimulus, sample-level model and per-cycle comparison
module tb_wave_sample_packer;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        half_full;
  logic [31:0] word_count;

  int checks = 0;
  int failures = 0;

  wave_sample_packer #(.PAD(16'h0000)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .half_full(half_full), .word_count(word_count)
  );

  always #5 aclk = ~aclk;

  // Model: a held sample (if any), a pending-flush flag, a queue of produced words, and a count
  logic        md_held = 1'b0;
  logic [15:0] md_val = '0;
  logic        md_pend = 1'b0;
  logic [32:0] md_q[$];
  logic [31:0] md_cnt = '0;
  logic [32:0] obs[$];

  function automatic logic exp_ready();
    return !areset && enable && !md_pend && (!md_held || md_q.size() == 0 || m_ready);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      md_held = 1'b0;
      md_val  = '0;
      md_pend = 1'b0;
      md_q.delete();
      md_cnt  = '0;
    end else begin
      automatic logic free = md_q.size() == 0 || m_ready;
      automatic logic take = s_valid && exp_ready();
      automatic logic pend_was = md_pend;
      if (md_q.size() != 0 && m_ready) begin
        void'(md_q.pop_front());
        md_cnt = md_cnt + 1;
      end
      if (pend_was) begin
        if (!md_held) md_pend = 1'b0;
        else if (free) begin
          md_q.push_back({1'b1, 16'h0000, md_val});
          md_held = 1'b0;
          md_pend = 1'b0;
        end
      end else begin
        if (take && !md_held) begin
          md_held = 1'b1;
          md_val  = s_data;
        end else if (take) begin
          md_q.push_back({1'b0, s_data, md_val});
          md_held = 1'b0;
        end
        if (flush) md_pend = 1'b1;
      end
    end
  end

  always @(posedge aclk) if (!areset && m_valid && m_ready) obs.push_back({m_last, m_data});

  always @(negedge aclk) begin
    chk("s_ready", s_ready, exp_ready());
    chk("half_full", half_full, md_held);
    chk("m_valid", m_valid, md_q.size() != 0);
    chk("word_count", word_count, md_cnt);
    if (md_q.size() != 0) begin
      chk("m_data", m_data, md_q[0][31:0]);
      chk("m_last", m_last, md_q[0][32]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic send(input logic [15:0] d);
    s_data = d;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    int base;
    step(2);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_count", word_count, 0);
    areset = 1'b0;
    enable = 1'b1;
    step();

    // Two full words streaming back to back
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    step(3);
    chk("stream_w0", obs[0], {1'b0, 32'h22221111});
    chk("stream_w1", obs[1], {1'b0, 32'h44443333});
    chk("stream_cnt", word_count, 2);

    // Flush of a single held sample
    send(16'hAAAA);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(3);
    chk("flush_w", obs[2], {1'b1, 32'h0000AAAA});
    chk("flush_half", half_full, 0);
    chk("flush_cnt", word_count, 3);

    // Backpressure: one extra sample accepted, then input stalls with m_data stable
    m_ready = 1'b0;
    send(16'h0101); send(16'h0202); send(16'h0303);
    s_data = 16'h0404;
    s_valid = 1'b1;
    #1;
    chk("bp_stall", s_ready, 0);
    step(2);
    chk("bp_stall2", s_ready, 0);
    chk("bp_data", m_data, 32'h02020101);
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    step(3);
    chk("bp_w0", obs[3], {1'b0, 32'h02020101});
    chk("bp_w1", obs[4], {1'b0, 32'h04040303});

    // Flush with nothing held: flag clears, no word
    base = obs.size();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fe_pending", s_ready, 0);
    step();
    chk("fe_ready", s_ready, 1);
    step(2);
    chk("fe_noword", obs.size(), base);

    // Flush in the same cycle as an even sample pads that sample
    s_data = 16'hBBBB;
    s_valid = 1'b1;
    flush = 1'b1;
    step();
    s_valid = 1'b0;
    flush = 1'b0;
    step(4);
    chk("fs_w", obs[obs.size()-1], {1'b1, 32'h0000BBBB});

    // Disabling keeps the held even sample
    send(16'hCCCC);
    enable = 1'b0;
    s_data = 16'hDDDD;
    s_valid = 1'b1;
    step(2);
    chk("en_half", half_full, 1);
    chk("en_blocked", s_ready, 0);
    enable = 1'b1;
    step();
    s_valid = 1'b0;
    step(3);
    chk("en_w", obs[obs.size()-1], {1'b0, 32'hDDDDCCCC});

    // Counter wrap
    force dut.word_count = 32'hFFFF_FFFF;
    #1;
    release dut.word_count;
    md_cnt = 32'hFFFF_FFFF;
    send(16'h7777); send(16'h8888);
    step(3);
    chk("wrap_cnt", word_count, 0);

    // Asynchronous reset mid-word
    m_ready = 1'b0;
    send(16'h0001); send(16'h0002); send(16'h0003);
    #1;
    areset = 1'b1;
    #1;
    chk("ar_m_valid", m_valid, 0);
    chk("ar_half", half_full, 0);
    chk("ar_s_ready", s_ready, 0);
    chk("ar_count", word_count, 0);
    step();
    areset = 1'b0;
    m_ready = 1'b1;
    base = obs.size();
    send(16'h5555); send(16'h6666);
    step(3);
    chk("ar_nword", obs.size(), base + 1);
    chk("ar_w", obs[obs.size()-1], {1'b0, 32'h66665555});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
